// File: rtl/booth_radix4_multiplier.sv
// Registered 8-bit add / subtract / radix-4 Booth multiply behind a start/done handshake.
// Build option UNSIGNED_MUL_EN: multiply treats a and b as unsigned (5 iterations instead of 4).
module booth_radix4_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cin,
  output logic [15:0] result,
  output logic        cout,
  output logic        busy,
  output logic        done
);

`ifdef UNSIGNED_MUL_EN
  localparam int         MW   = 10;
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam int         MW   = 8;
  localparam logic [2:0] LAST = 3'd3;
`endif

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_nxt;
  logic          load_mul, addsub_go, mul_last, is_sub;
  logic signed [11:0] mc_p0, hi_p0;
  logic [MW-1:0] lo_p0;
  logic          q_p0;
  logic [2:0]    cnt_p0;

  logic [11:0]   add_x, add_y, add_sum;
  logic          add_ci, add_c8;
  logic [11:0]   next_hi;
  logic [MW-1:0] next_lo;

  // 12-bit adder built from three 4-bit carry-skip blocks; also returns the carry out of bit 7.
  function automatic logic [12:0] cskip_add(input logic [11:0] x, input logic [11:0] y,
                                            input logic ci);
    logic [11:0] p, g, s;
    logic        c, blk_c, c8;
    p  = x ^ y;
    g  = x & y;
    c  = ci;
    c8 = 1'b0;
    s  = '0;
    for (int blk = 0; blk < 3; blk++) begin
      blk_c = c;
      for (int i = 0; i < 4; i++) begin
        s[4*blk+i] = p[4*blk+i] ^ c;
        c          = g[4*blk+i] | (p[4*blk+i] & c);
      end
      if (&p[4*blk +: 4]) c = blk_c;
      if (blk == 1) c8 = c;
    end
    return {c8, s};
  endfunction

  assign is_sub = (op == 2'b01);
  assign busy   = (state == MUL);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_mul  = 1'b0;
    addsub_go = 1'b0;
    mul_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == 2'b10) begin
            load_mul  = 1'b1;
            state_nxt = MUL;
          end else begin
            addsub_go = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_p0 == 3'd0) begin
          mul_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Adder is shared: Booth digit times multiplicand while multiplying, the ports otherwise.
  always_comb begin
    add_x  = {4'h0, a};
    add_y  = is_sub ? {4'h0, ~b} : {4'h0, b};
    add_ci = is_sub ? ~cin : cin;
    if (state == MUL) begin
      add_x = hi_p0;
      case ({lo_p0[1:0], q_p0})
        3'b001, 3'b010: begin add_y = mc_p0;                  add_ci = 1'b0; end
        3'b011:         begin add_y = {mc_p0[10:0], 1'b0};    add_ci = 1'b0; end
        3'b100:         begin add_y = ~{mc_p0[10:0], 1'b0};   add_ci = 1'b1; end
        3'b101, 3'b110: begin add_y = ~mc_p0;                 add_ci = 1'b1; end
        default:        begin add_y = '0;                     add_ci = 1'b0; end
      endcase
    end
    {add_c8, add_sum} = cskip_add(add_x, add_y, add_ci);
    next_hi = {add_sum[11], add_sum[11], add_sum[11:2]};
    next_lo = {add_sum[1:0], lo_p0[MW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
      mc_p0  <= '0;
      hi_p0  <= '0;
      lo_p0  <= '0;
      q_p0   <= 1'b0;
      cnt_p0 <= '0;
    end else begin
      done <= 1'b0;
      if (addsub_go) begin
        result <= {8'h00, add_sum[7:0]};
        cout   <= is_sub ? ~add_c8 : add_c8;
        done   <= 1'b1;
      end
      if (load_mul) begin
`ifdef UNSIGNED_MUL_EN
        mc_p0 <= {4'h0, a};
        lo_p0 <= {2'b00, b};
`else
        mc_p0 <= {{4{a[7]}}, a};
        lo_p0 <= b;
`endif
        hi_p0  <= '0;
        q_p0   <= 1'b0;
        cnt_p0 <= LAST;
      end
      if (state == MUL) begin
        hi_p0  <= next_hi;
        lo_p0  <= next_lo;
        q_p0   <= lo_p0[1];
        cnt_p0 <= cnt_p0 - 3'd1;
        if (mul_last) begin
          result <= {next_hi[15-MW:0], next_lo};
          cout   <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier: add/sub vectors, multiply latency and products,
// busy-time start rejection and reset abort.
module tb_booth_radix4_multiplier;

`ifdef UNSIGNED_MUL_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, cin;
  logic [1:0]  op;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic        cout, busy, done;

  int total = 0;
  int bad   = 0;

  booth_radix4_multiplier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .result(result), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_addsub(input string tag, input logic [1:0] o, input logic [7:0] xa,
                            input logic [7:0] xb, input logic c, input logic [15:0] er,
                            input logic ec);
    @(negedge clk);
    op = o; a = xa; b = xb; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h5A; b = 8'hA5; cin = ~c;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(er));
  endtask

  task automatic run_mul(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [15:0] er);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    op = 2'b10; a = xa; b = xb; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~xa; b = ~xb;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 12) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(N));
    chk({tag, "_busy_hi"}, 32'(busy_ok), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_addsub("add1", 2'b00, 8'h07, 8'h0F, 1'b0, 16'h0016, 1'b0);
    run_addsub("add2", 2'b00, 8'hFF, 8'h01, 1'b1, 16'h0001, 1'b1);
    run_addsub("add3", 2'b00, 8'h0F, 8'hF0, 1'b1, 16'h0000, 1'b1);
    run_addsub("sub1", 2'b01, 8'h16, 8'h0F, 1'b0, 16'h0007, 1'b0);
    run_addsub("sub2", 2'b01, 8'h00, 8'h01, 1'b0, 16'h00FF, 1'b1);
    run_addsub("rsvd", 2'b11, 8'h20, 8'h22, 1'b1, 16'h0043, 1'b0);

    for (int i = 1; i <= 7; i++)
      run_mul($sformatf("mul%0d", i), 8'(i), 8'(i + 8), 16'(i * (i + 8)));

`ifdef UNSIGNED_MUL_EN
    run_mul("umul_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_mul("umul_80", 8'h80, 8'h80, 16'h4000);
`else
    run_mul("smul_80", 8'h80, 8'h80, 16'h4000);
    run_mul("smul_ff02", 8'hFF, 8'h02, 16'hFFFE);
    run_mul("smul_7f81", 8'h7F, 8'h81, 16'hC0FF);
`endif

    // second start while busy must be ignored
    @(negedge clk);
    op = 2'b10; a = 8'h03; b = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    op = 2'b10; a = 8'h09; b = 8'h09; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'(N));
    chk("ign_res", 32'(result), 32'h000F);
    @(posedge clk); #1;
    chk("ign_noqueue", 32'(busy), 32'd0);

    // reset two cycles into a multiply
    @(negedge clk);
    op = 2'b10; a = 8'h07; b = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);

    run_addsub("post_add", 2'b00, 8'h03, 8'h04, 1'b0, 16'h0007, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
